// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch stage: reset PC default, bubble
// instruction, RUN/HOLD state encoding and RV32I major opcodes.
package pc_fetch_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0100_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // addi x0, x0, 0

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } fetch_state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/pc_fetch_hold_buf.sv
// fetch_hold_buf: single-entry hold register plus RUN/HOLD FSM.
// On the first stall cycle the presented instruction is captured and
// replayed until the stall is released; a redirect always returns to RUN.
module fetch_hold_buf
   import pc_fetch_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] inst_i,
   input  logic        valid_i,
   output logic [31:0] inst_o,
   output logic        valid_o
);

   fetch_state_t state_q, state_d;
   logic [31:0]  hold_inst_q, hold_inst_d;
   logic         hold_valid_q, hold_valid_d;

   // State and hold-register update
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= RUN;
         hold_inst_q  <= NOP_INST;
         hold_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_inst_q  <= hold_inst_d;
         hold_valid_q <= hold_valid_d;
      end
   end

   // Next state: redirect wins, otherwise stall enters/keeps HOLD
   always_comb begin
      state_d      = state_q;
      hold_inst_d  = hold_inst_q;
      hold_valid_d = hold_valid_q;
      if (redirect_i) begin
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (stall_i) begin
                  state_d      = HOLD;
                  hold_inst_d  = inst_i;
                  hold_valid_d = valid_i;
               end
            end
            HOLD: begin
               if (!stall_i) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Output select: live data in RUN, captured data in HOLD
   always_comb begin
      inst_o  = inst_i;
      valid_o = valid_i;
      if (state_q == HOLD) begin
         inst_o  = hold_inst_q;
         valid_o = hold_valid_q;
      end
   end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: fetch stage of the RV32I pipeline. Owns the PC, drives the
// 1-cycle-latency instruction memory and presents PC_f/inst_f/valid_f.
// Optional macro FETCH_PERF_CNT_EN adds instruction/bubble/redirect counters.
module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_f,
   output logic [31:0] inst_f,
   output logic        valid_f
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_inst_cnt,
   output logic [31:0] perf_bubble_cnt,
   output logic [31:0] perf_redirect_cnt
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] rsp_pc_q, rsp_pc_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] run_inst;

   // PC and response-tag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q        <= RESET_PC;
         rsp_pc_q    <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         rsp_pc_q    <= rsp_pc_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Address generation: redirect over stall over sequential advance
   always_comb begin
      pc_d        = pc_q;
      rsp_pc_d    = rsp_pc_q;
      rsp_valid_d = rsp_valid_q;
      if (redirect) begin
         pc_d        = redirect_pc & ~32'h3;
         rsp_valid_d = 1'b0;
      end else if (!stall) begin
         rsp_pc_d    = pc_q;
         rsp_valid_d = 1'b1;
         pc_d        = pc_q + 32'd4;
      end
   end

   // Live (RUN-state) instruction: returning data or a bubble
   always_comb begin
      run_inst = rsp_valid_q ? imem_rdata : NOP_INST;
   end

   fetch_hold_buf u_hold_buf (
      .clk_i      (clk),
      .reset_i    (reset),
      .stall_i    (stall),
      .redirect_i (redirect),
      .inst_i     (run_inst),
      .valid_i    (rsp_valid_q),
      .inst_o     (inst_f),
      .valid_o    (valid_f)
   );

   // rsp_pc is frozen while held, so one select serves both FSM states
   always_comb begin
      imem_addr = pc_q;
      PC_f      = valid_f ? rsp_pc_q : '0;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] inst_cnt_q, bubble_cnt_q, redirect_cnt_q;

   // Performance counters, free-wrapping
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_cnt_q     <= '0;
         bubble_cnt_q   <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (!stall &&  valid_f) inst_cnt_q     <= inst_cnt_q + 32'd1;
         if (!stall && !valid_f) bubble_cnt_q   <= bubble_cnt_q + 32'd1;
         if (redirect)           redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign perf_inst_cnt     = inst_cnt_q;
   assign perf_bubble_cnt   = bubble_cnt_q;
   assign perf_redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed-vector bench for pc_fetch with a 1-cycle-latency memory model.
module tb_pc_fetch;

   localparam logic [31:0] RPC = 32'h0100_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic [31:0] PC_f;
   logic [31:0] inst_f;
   logic        valid_f;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_inst_cnt, perf_bubble_cnt, perf_redirect_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   pc_fetch #(.RESET_PC(RPC)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .PC_f        (PC_f),
      .inst_f      (inst_f),
      .valid_f     (valid_f)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_inst_cnt     (perf_inst_cnt),
      .perf_bubble_cnt   (perf_bubble_cnt),
      .perf_redirect_cnt (perf_redirect_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
   endfunction

   always @(posedge clk) imem_rdata <= memword(imem_addr);

   typedef struct {
      logic        rst;
      logic        stl;
      logic        rdr;
      logic [31:0] rpc;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic        e_valid;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst, input logic stl, input logic rdr,
                      input logic [31:0] rpc, input logic [31:0] e_addr,
                      input logic [31:0] e_pc, input logic e_valid);
      vec_t v;
      v.rst = rst; v.stl = stl; v.rdr = rdr; v.rpc = rpc;
      v.e_addr = e_addr; v.e_pc = e_pc; v.e_valid = e_valid;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx,
                      input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   // Compare all outputs against an expected presentation
   task automatic check_outputs(input string tag, input int idx,
                                input logic [31:0] e_addr,
                                input logic [31:0] e_pc, input logic e_valid);
      logic [31:0] e_inst;
      e_inst = e_valid ? memword(e_pc) : NOP;
      vectors++;
      chk({tag, "_addr"},  idx, imem_addr, e_addr);
      chk({tag, "_pc"},    idx, PC_f, e_valid ? e_pc : 32'h0);
      chk({tag, "_inst"},  idx, inst_f, e_inst);
      chk({tag, "_valid"}, idx, {31'b0, valid_f}, {31'b0, e_valid});
   endtask

   task automatic drive(input logic rst, input logic stl, input logic rdr,
                        input logic [31:0] rpc);
      @(negedge clk);
      reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
      #1;
   endtask

   initial begin
      // rst stl rdr  rpc           addr           pc             v
      add(1, 0, 0, 32'h0,         RPC,           32'h0,         0); // reset state
      add(0, 0, 0, 32'h0,         RPC,           32'h0,         0); // startup bubble
      add(0, 0, 0, 32'h0,         RPC + 4,       RPC,           1);
      add(0, 0, 0, 32'h0,         RPC + 8,       RPC + 4,       1);
      add(0, 1, 0, 32'h0,         RPC + 12,      RPC + 8,       1); // stall x3
      add(0, 1, 0, 32'h0,         RPC + 12,      RPC + 8,       1);
      add(0, 1, 0, 32'h0,         RPC + 12,      RPC + 8,       1);
      add(0, 0, 0, 32'h0,         RPC + 12,      RPC + 8,       1); // release
      add(0, 0, 0, 32'h0,         RPC + 16,      RPC + 12,      1);
      add(0, 0, 1, 32'h0100_0100, RPC + 20,      RPC + 16,      1); // redirect
      add(0, 0, 0, 32'h0,         32'h0100_0100, 32'h0,         0);
      add(0, 0, 0, 32'h0,         32'h0100_0104, 32'h0100_0100, 1);
      add(0, 1, 1, 32'h0100_0200, 32'h0100_0108, 32'h0100_0104, 1); // redirect+stall
      add(0, 1, 0, 32'h0,         32'h0100_0200, 32'h0,         0);
      add(0, 1, 0, 32'h0,         32'h0100_0200, 32'h0,         0);
      add(0, 0, 0, 32'h0,         32'h0100_0200, 32'h0,         0);
      add(0, 0, 0, 32'h0,         32'h0100_0204, 32'h0100_0200, 1);
      add(0, 0, 1, 32'h0100_0103, 32'h0100_0208, 32'h0100_0204, 1); // unaligned target
      add(0, 0, 0, 32'h0,         32'h0100_0100, 32'h0,         0);
      add(0, 0, 1, 32'hFFFF_FFFE, 32'h0100_0104, 32'h0100_0100, 1);
      add(0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'h0,         0);
      add(0, 0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 1); // wrap
      add(0, 0, 0, 32'h0,         32'h0000_0004, 32'h0000_0000, 1);
      add(0, 1, 0, 32'h0,         32'h0000_0008, 32'h0000_0004, 1); // enter HOLD
      add(0, 1, 0, 32'h0,         32'h0000_0008, 32'h0000_0004, 1);
      add(1, 1, 0, 32'h0,         32'h0000_0008, 32'h0000_0004, 1); // reset mid-HOLD
      add(1, 1, 1, 32'h0100_0300, RPC,           32'h0,         0); // reset beats redirect
      add(0, 0, 0, 32'h0,         RPC,           32'h0,         0);
      add(0, 0, 0, 32'h0,         RPC + 4,       RPC,           1);
      add(0, 1, 0, 32'h0,         RPC + 8,       RPC + 4,       1);
      add(0, 1, 0, 32'h0,         RPC + 8,       RPC + 4,       1);
      add(0, 0, 1, 32'h0100_0300, RPC + 8,       RPC + 4,       1); // redirect from HOLD
      add(0, 0, 0, 32'h0,         32'h0100_0300, 32'h0,         0);
      add(0, 0, 0, 32'h0,         32'h0100_0304, 32'h0100_0300, 1);

      // initial reset so the first checked vector sees settled state
      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc);
         check_outputs("vec", i, vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_valid);
      end

      // Throughput: after a redirect, one instruction per cycle for 8 cycles
      drive(0, 0, 1, 32'h0200_0000);
      drive(0, 0, 0, 32'h0);
      check_outputs("tp_bubble", 0, 32'h0200_0000, 32'h0, 0);
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 0, 32'h0);
         check_outputs("tp", k, 32'h0200_0004 + 32'(k) * 4,
                       32'h0200_0000 + 32'(k) * 4, 1);
      end

      // Long stall entered on a bubble, with a redirect landing mid-stall
      drive(0, 1, 1, 32'h0300_0000);
      drive(0, 1, 0, 32'h0);
      check_outputs("ls", 0, 32'h0300_0000, 32'h0, 0);
      drive(0, 1, 1, 32'h0300_0040);
      check_outputs("ls", 1, 32'h0300_0000, 32'h0, 0);
      drive(0, 1, 0, 32'h0);
      check_outputs("ls", 2, 32'h0300_0040, 32'h0, 0);
      drive(0, 0, 0, 32'h0);
      check_outputs("ls", 3, 32'h0300_0040, 32'h0, 0);
      drive(0, 0, 0, 32'h0);
      check_outputs("ls", 4, 32'h0300_0044, 32'h0300_0040, 1);

`ifdef FETCH_PERF_CNT_EN
      // 10 free-running cycles with a redirect in the 10th, then its bubble
      drive(1, 0, 0, 32'h0);
      drive(1, 0, 0, 32'h0);
      for (int c = 1; c <= 11; c++) begin
         drive(0, 0, (c == 10), 32'h0100_0800);
      end
      drive(0, 1, 0, 32'h0);
      vectors++;
      chk("perf_inst",     0, perf_inst_cnt,     32'd9);
      chk("perf_bubble",   0, perf_bubble_cnt,   32'd2);
      chk("perf_redirect", 0, perf_redirect_cnt, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Fetch stage of the pipelined RV32I core, directly upstream of the fetch/decode pipeline register. Owns the program counter, drives the synchronous instruction memory (1-cycle read latency), and presents `PC_f`/`inst_f` to the fetch/decode register every cycle. Handles decode-stage stalls without dropping an instruction and execute-stage redirects (taken branch/jump), inserting NOP bubbles where fetched data is invalid.

## Interface
- `RESET_PC`, default 32'h01000000: first fetch address after reset.
- `clk` in 1: core clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: decode hazard stall; the fetch/decode register holds while this is high.
- `redirect` in 1: execute-stage taken branch/jump.
- `redirect_pc` in 32: redirect target; bits [1:0] forced to 0.
- `imem_addr` out 32: instruction memory read address (= `pc_q`).
- `imem_rdata` in 32: data for the address presented in the previous cycle.
- `PC_f` out 32: PC of the presented instruction; 0 for a bubble.
- `inst_f` out 32: presented instruction; 32'h13 for a bubble.
- `valid_f` out 1: 1 = real instruction, 0 = bubble.

## Operation
- State: `pc_q` (address issued this cycle), `rsp_pc`, `rsp_valid` (tag for the returning data), FSM {RUN, HOLD}, `hold_inst`/`hold_valid`.
- RUN outputs: `valid_f = rsp_valid`; `inst_f = rsp_valid ? imem_rdata : 32'h13`; `PC_f = rsp_valid ? rsp_pc : 0`.
- HOLD outputs: `inst_f = hold_inst`, `valid_f = hold_valid`, `PC_f = hold_valid ? rsp_pc : 0`.
- Advance: RUN with `!stall`, or HOLD with `!stall`.
  - `rsp_pc <= pc_q`, `rsp_valid <= 1`, `pc_q <= pc_q + 4` (mod 2^32), state RUN.
- RUN with `stall`:
  - Capture the current outputs: `hold_inst <= inst_f`, `hold_valid <= valid_f`.
  - `pc_q` and `rsp_pc` hold; state goes to HOLD.
  - Memory keeps returning `mem[pc_q]`; this data is ignored while in HOLD.
- HOLD with `stall`: everything holds.
- `redirect`, in any state, takes priority over `stall` and the advance:
  - `pc_q <= {redirect_pc[31:2], 2'b00}`, `rsp_valid <= 0`, state RUN.
  - The redirect is never lost, even when `stall` is high in the same cycle.
- Redirect followed by `stall`: the bubble is captured into HOLD with `hold_valid = 0`. The target instruction is presented on the first cycle after `stall` falls.

## Timing
- Reset values: `pc_q = RESET_PC`, `rsp_valid = 0`, state RUN, `hold_inst = 32'h13`, `hold_valid = 0`.
- Outputs during reset and on the first cycle after it: `imem_addr = RESET_PC`, `PC_f = 0`, `inst_f = 32'h13`, `valid_f = 0`.
- Reset has priority over `redirect` and `stall`. Reset mid-HOLD returns to RUN at `RESET_PC`.
- Startup: cycle 1 after reset is a bubble; cycle 2 presents `PC_f = RESET_PC`.
- Redirect asserted in cycle t:
  - t+1: `imem_addr = target`, bubble output.
  - t+2: `PC_f = target`, `inst_f = mem[target]`.
  - Squashing the instruction presented in cycle t is the fetch/decode register's job (its kill input).
- Stall: the output is stable from the first stall cycle through the release cycle inclusive. The instruction after it appears the cycle after release with zero extra latency.
- Throughput: 1 instruction/cycle with no stall or redirect.
- Wrap: 32'hFFFFFFFC + 4 = 32'h00000000.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds output ports `perf_inst_cnt`, `perf_bubble_cnt`, `perf_redirect_cnt` (32 bits each).
  - Each counts a cycle with `!stall` && `valid_f`, `!stall` && `!valid_f`, and `redirect` respectively.
  - Each resets to 0 and wraps modulo 2^32.
- Not defined: ports and counters are absent; fetch behaviour is identical.

## Structure
- Shared package holds: `RESET_PC` default, `NOP_INST` = 32'h13, the FSM state encoding {RUN, HOLD}, and the existing opcode constants.
- One sub-module, `fetch_hold_buf`:
  - The single-entry hold register plus RUN/HOLD FSM.
  - Inputs `stall`, `redirect`, current inst/valid; outputs the selected inst/valid.
- `pc_fetch` keeps the PC/tag registers, address generation and the optional perf counters.

## Test plan
- Reset released, no stall/redirect, `RESET_PC` = 0x01000000 → cycle 1 bubble, then `PC_f` = 0x01000000, 0x01000004, 0x01000008 with matching `mem` words.
- `stall` high 3 cycles while presenting PC 0x01000008 → `PC_f`/`inst_f` hold 0x01000008 through the release cycle; next cycle `PC_f` = 0x0100000C.
- `redirect` with target 0x01000100 → next cycle bubble (0, 32'h13, `valid_f` = 0), then `PC_f` = 0x01000100.
- `redirect` (target 0x01000200) and `stall` together, `stall` held 2 more cycles → bubble held during the stall, then 0x01000200 presented after `stall` falls.
- `redirect_pc` = 0x01000103 → `imem_addr` = 0x01000100; PC 0xFFFFFFFC advances to 0x00000000.
- `FETCH_PERF_CNT_EN`: 10 free-running cycles plus 1 redirect after reset → `perf_inst_cnt` = 9, `perf_bubble_cnt` = 2, `perf_redirect_cnt` = 1.
